// File: rtl/datapath_sequencer.sv
// datapath_sequencer: configures the FIFO/MUX/DEMUX datapath and streams a
// programmed number of symbols from the upstream FIFO into the downstream FIFO.
//
// Ports:
//   inClock        system clock, rising edge
//   inReset        asynchronous active-low reset
//   inStart        start request, sampled only in IDLE
//   inAbort        abort current frame (priority over inStart)
//   inMode         0=standalone 1=TX 2=RX 3=loopback
//   inFrameLen     number of symbols to transfer (latched on start)
//   inFifoEmpty    upstream FIFO empty flag
//   inFifoFull     downstream FIFO full flag
//   outReadEnable  upstream FIFO read strobe (combinational)
//   outWriteEnable downstream FIFO write strobe (read delayed one cycle)
//   outSelBus      packed MUX/DEMUX selects
//   outBusy        high in SETTLE, STREAM and DRAIN
//   outDone        one-cycle pulse on frame completion
//   outError       one-cycle pulse on a rejected (zero-length) start
//   outCount       symbols read in the current or last frame
module datapath_sequencer #(
  parameter int unsigned LEN_WIDTH     = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                 inClock,
  input  logic                 inReset,
  input  logic                 inStart,
  input  logic                 inAbort,
  input  logic [1:0]           inMode,
  input  logic [LEN_WIDTH-1:0] inFrameLen,
  input  logic                 inFifoEmpty,
  input  logic                 inFifoFull,
  output logic                 outReadEnable,
  output logic                 outWriteEnable,
  output logic [15:0]          outSelBus,
  output logic                 outBusy,
  output logic                 outDone,
  output logic                 outError,
  output logic [LEN_WIDTH-1:0] outCount
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           state_q,  state_d;
  logic [LEN_WIDTH-1:0] len_q,    len_d;
  logic [LEN_WIDTH-1:0] cnt_q,    cnt_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [15:0]          sel_q,    sel_d;
  logic                 wr_q,     wr_d;
  logic                 busy_q,   busy_d;
  logic                 done_q,   done_d;
  logic                 err_q,    err_d;
  logic                 rd_c;
  logic [LEN_WIDTH-1:0] cnt_inc;

  // Mode-specific select word for all MUX/DEMUX select lines
  function automatic logic [15:0] sel_word(input logic [1:0] mode);
    case (mode)
      2'd1:    sel_word = 16'h26A0;
      2'd2:    sel_word = 16'h481B;
      2'd3:    sel_word = 16'h6F44;
      default: sel_word = 16'h0000;
    endcase
  endfunction

  assign cnt_inc = cnt_q + LEN_WIDTH'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    sel_d    = sel_q;
    err_d    = 1'b0;
    rd_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort in IDLE drops a simultaneous start
        if (inStart && !inAbort) begin
          if (inFrameLen == '0) begin
            err_d = 1'b1;
          end else begin
            len_d    = inFrameLen;
            sel_d    = sel_word(inMode);
            cnt_d    = '0;
            settle_d = SET_W'(SETTLE_CYCLES);
            state_d  = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (inAbort) begin
          state_d = S_IDLE;
        end else if (settle_q == SET_W'(1)) begin
          state_d = S_STREAM;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      S_STREAM: begin
        if (inAbort) begin
          state_d = S_IDLE;
        end else if (!inFifoEmpty && !inFifoFull) begin
          rd_c  = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = inAbort ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Write follows the read by one cycle to match FIFO read latency;
    // an abort suppresses the read and therefore the pending write.
    wr_d   = rd_c;
    busy_d = (state_d == S_SETTLE) || (state_d == S_STREAM) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      sel_q    <= 16'h0000;
      wr_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign outReadEnable  = rd_c;
  assign outWriteEnable = wr_q;
  assign outSelBus      = sel_q;
  assign outBusy        = busy_q;
  assign outDone        = done_q;
  assign outError       = err_q;
  assign outCount       = cnt_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: the driver predicts reads, writes,
// done and error events frame by frame; a monitor compares them as they occur.
module tb_datapath_sequencer;

  localparam int unsigned LW = 8;
  localparam int unsigned SC = 2;

  localparam logic [1:0] EV_WR   = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [15:0]   sel;
    logic [LW-1:0] cnt;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort_r, fifo_empty, fifo_full;
  logic [1:0]    mode;
  logic [LW-1:0] frame_len;
  logic          rd_en, wr_en, busy, done, err;
  logic [15:0]   sel_bus;
  logic [LW-1:0] count;

  ev_t           evq[$];
  bit            rdq[$];
  int            checks = 0;
  int            errors = 0;
  logic [15:0]   m_sel;
  logic [LW-1:0] m_cnt;

  always #5 clk = ~clk;

  datapath_sequencer #(.LEN_WIDTH(LW), .SETTLE_CYCLES(SC)) dut (
    .inClock(clk), .inReset(rst_n), .inStart(start), .inAbort(abort_r),
    .inMode(mode), .inFrameLen(frame_len), .inFifoEmpty(fifo_empty),
    .inFifoFull(fifo_full), .outReadEnable(rd_en), .outWriteEnable(wr_en),
    .outSelBus(sel_bus), .outBusy(busy), .outDone(done), .outError(err),
    .outCount(count)
  );

  function automatic logic [15:0] sel_of(input int md);
    case (md)
      1:       return 16'h26A0;
      2:       return 16'h481B;
      3:       return 16'h6F44;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_event(input logic [1:0] kind);
    ev_t ev;
    if (evq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      ev = evq.pop_front();
      chk("event_kind", 32'(kind), 32'(ev.kind));
      chk("event_sel", 32'(sel_bus), 32'(ev.sel));
      chk("event_count", 32'(count), 32'(ev.cnt));
      chk("event_busy", 32'(busy), (kind == EV_WR) ? 32'd1 : 32'd0);
    end
  endtask

  // Monitor: mid-cycle sampling of read strobe and output events
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdq.size() > 0) chk("read_enable", 32'(rd_en), 32'(rdq.pop_front()));
      if (wr_en) expect_event(EV_WR);
      if (done)  expect_event(EV_DONE);
      if (err)   expect_event(EV_ERR);
    end
  end

  // One cycle: record expected read strobe, advance past the next edge
  task automatic step(input bit rd_exp);
    rdq.push_back(rd_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd"},    32'(rd_en),   32'd0);
    chk({tag, "_wr"},    32'(wr_en),   32'd0);
    chk({tag, "_sel"},   32'(sel_bus), 32'd0);
    chk({tag, "_busy"},  32'(busy),    32'd0);
    chk({tag, "_done"},  32'(done),    32'd0);
    chk({tag, "_err"},   32'(err),     32'd0);
    chk({tag, "_count"}, 32'(count),   32'd0);
  endtask

  // stall: 0 none, 1 random, 2 scripted empty/full; abort_after<0 means no abort
  task automatic run_frame(input int md, input int len, input int stall,
                           input int abort_after, input bit mid_start);
    int reads;
    int sc;
    bit e;
    bit f;
    mode = 2'(md); frame_len = LW'(len); start = 1'b1; abort_r = 1'b0;
    fifo_empty = 1'b0; fifo_full = 1'b0;
    m_sel = sel_of(md);
    m_cnt = '0;
    step(0);
    start = 1'b0;
    for (int s = 0; s < int'(SC); s++) begin
      fifo_empty = 1'($urandom); fifo_full = 1'($urandom);
      mode = 2'($urandom); frame_len = LW'($urandom);
      step(0);
    end
    reads = 0;
    sc = 0;
    while (reads < len) begin
      case (stall)
        1: begin
          e = ($urandom % 4) == 0;
          f = ($urandom % 5) == 0;
          if (sc > 40) begin e = 1'b0; f = 1'b0; end
        end
        2: begin
          e = (sc < 3);
          f = (sc == 5) || (sc == 6);
        end
        default: begin e = 1'b0; f = 1'b0; end
      endcase
      mode = 2'($urandom); frame_len = LW'($urandom);
      start = mid_start && (($urandom % 3) == 0);
      if (abort_after >= 0 && reads == abort_after) begin
        fifo_empty = 1'b0; fifo_full = 1'b0; abort_r = 1'b1;
        step(0);
        abort_r = 1'b0; start = 1'b0;
        chk("abort_busy",  32'(busy),    32'd0);
        chk("abort_done",  32'(done),    32'd0);
        chk("abort_count", 32'(count),   32'(m_cnt));
        chk("abort_sel",   32'(sel_bus), 32'(m_sel));
        return;
      end
      fifo_empty = e; fifo_full = f;
      if (!e && !f) begin
        reads++;
        m_cnt = m_cnt + LW'(1);
        evq.push_back(ev_t'{EV_WR, m_sel, m_cnt});
        step(1);
      end else begin
        step(0);
      end
      sc++;
    end
    // Drain cycle then done cycle; starts here must be ignored
    fifo_empty = 1'($urandom); fifo_full = 1'($urandom);
    start = mid_start;
    evq.push_back(ev_t'{EV_DONE, m_sel, m_cnt});
    step(0);
    step(0);
    start = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;
  endtask

  task automatic error_start();
    start = 1'b1; frame_len = '0; mode = 2'($urandom);
    evq.push_back(ev_t'{EV_ERR, m_sel, m_cnt});
    step(0);
    start = 1'b0;
    step(0);
    step(0);
    chk("error_busy", 32'(busy),    32'd0);
    chk("error_sel",  32'(sel_bus), 32'(m_sel));
  endtask

  initial begin
    int len;
    rst_n = 1'b0; start = 1'b0; abort_r = 1'b0; mode = '0; frame_len = '0;
    fifo_empty = 1'b0; fifo_full = 1'b0;
    m_sel = '0; m_cnt = '0;
    repeat (5) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    step(0);
    chk("post_reset_sel",  32'(sel_bus), 32'd0);
    chk("post_reset_busy", 32'(busy),    32'd0);

    run_frame(1, 3, 0, -1, 0);
    run_frame(2, 4, 2, -1, 0);
    error_start();

    // Abort with start in IDLE: start dropped, no error, no frame
    start = 1'b1; abort_r = 1'b1; frame_len = '0; mode = 2'd3;
    step(0);
    frame_len = LW'(5);
    step(0);
    start = 1'b0; abort_r = 1'b0;
    repeat (6) step(0);
    chk("drop_busy", 32'(busy),    32'd0);
    chk("drop_sel",  32'(sel_bus), 32'(m_sel));

    run_frame(3, 10, 0, 5, 0);
    run_frame(1, 2, 0, -1, 0);
    run_frame(0, 6, 1, -1, 1);
    run_frame(1, 1, 0, -1, 0);
    run_frame(2, 7, 1, 0, 0);
    error_start();
    run_frame(3, 255, 1, -1, 0);

    for (int i = 0; i < 25; i++) begin
      len = 1 + int'($urandom % 12);
      if (($urandom % 6) == 0) error_start();
      if (($urandom % 4) == 0)
        run_frame(int'($urandom % 4), len, 1, int'($urandom % len), 1'($urandom));
      else
        run_frame(int'($urandom % 4), len, 1, -1, 1'($urandom));
      if (($urandom % 3) == 0) step(0);
    end

    // Asynchronous reset in the middle of STREAM
    mode = 2'd3; frame_len = LW'(50); start = 1'b1;
    fifo_empty = 1'b0; fifo_full = 1'b0;
    m_sel = sel_of(3); m_cnt = '0;
    step(0);
    start = 1'b0;
    repeat (SC) step(0);
    for (int r = 0; r < 3; r++) begin
      m_cnt = m_cnt + LW'(1);
      evq.push_back(ev_t'{EV_WR, m_sel, m_cnt});
      step(1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    evq.delete();
    rdq.delete();
    m_sel = '0; m_cnt = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0);
    run_frame(2, 3, 0, -1, 0);

    repeat (4) step(0);
    chk("queue_empty", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
